dmem_arbiter: RTL

//  Shares the single-port data memory between the pipeline MEM stage (port C) and a DMA /

---
 rtl/dmem_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU MEM stage (port C)
// and a DMA/loader master (port D). Port C has priority; a wait counter forces D through
// after MAX_WAIT cycles of waiting. Memory commands are registered; read data is bypassed
// from mem_rdata during the rvalid cycle and held afterwards.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [31:0]   c_rdata,
  output logic          c_err,
  output logic          cpu_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned WW = AW - 2;
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] DepthIdx = WW'(DEPTH);
  localparam logic [CW-1:0] MaxWait  = CW'(MAX_WAIT);
  localparam logic [2:0]    ReadLat  = 3'(READ_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;  // 0 = port C, 1 = port D
  logic [2:0]      lat_cnt_q, lat_cnt_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            c_gnt_q, c_gnt_d, d_gnt_q, d_gnt_d;
  logic            c_err_q, c_err_d, d_err_q, d_err_d;
  logic            c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [31:0]     c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;

  logic            sel_c, sel_d, req_we, req_oor;
  logic [AW-1:0]   req_addr;
  logic [31:0]     req_wdata;

  // Arbitration on the live requests; only acted upon in StIdle.
  always_comb begin
    sel_c = 1'b0;
    sel_d = 1'b0;
    if (d_req && (wait_cnt_q == MaxWait)) begin
      sel_d = 1'b1;
    end else if (c_req) begin
      sel_c = 1'b1;
    end else if (d_req) begin
      sel_d = 1'b1;
    end
    req_we    = sel_d ? d_we    : c_we;
    req_addr  = sel_d ? d_addr  : c_addr;
    req_wdata = sel_d ? d_wdata : c_wdata;
    req_oor   = (req_addr[AW-1:2] >= DepthIdx);
  end

  // Starvation counter for port D: saturates while D waits, clears on grant or idle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!d_req || d_gnt_q) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // FSM next state and registered command/handshake outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    c_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    c_err_d     = 1'b0;
    d_err_d     = 1'b0;
    c_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (sel_c || sel_d) begin
          owner_d     = sel_d;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          mem_rd_d    = !req_we && !req_oor;
          mem_wr_d    = req_we && !req_oor;
          c_gnt_d     = sel_c;
          d_gnt_d     = sel_d;
          c_err_d     = sel_c && req_oor;
          d_err_d     = sel_d && req_oor;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // Only an in-range read raised mem_rd; writes and errors finish here.
        if (mem_rd_q) begin
          lat_cnt_d = ReadLat;
          state_d   = StWait;
          if (ReadLat == 3'd1) begin
            c_rvalid_d = !owner_q;
            d_rvalid_d = owner_q;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        // rvalid is registered, so raise it one cycle ahead of the final wait cycle.
        if (lat_cnt_q == 3'd2) begin
          c_rvalid_d = !owner_q;
          d_rvalid_d = owner_q;
        end
        if (lat_cnt_q == 3'd1) begin
          if (owner_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            c_rdata_d = mem_rdata;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; async reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      lat_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      c_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      c_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      c_gnt_q     <= c_gnt_d;
      d_gnt_q     <= d_gnt_d;
      c_err_q     <= c_err_d;
      d_err_q     <= d_err_d;
      c_rvalid_q  <= c_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign c_gnt     = c_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign c_err     = c_err_q;
  assign d_err     = d_err_q;
  assign c_rvalid  = c_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  // Memory data is only valid during the rvalid cycle, so pass it straight through then.
  assign c_rdata   = c_rvalid_q ? mem_rdata : c_rdata_q;
  assign d_rdata   = d_rvalid_q ? mem_rdata : d_rdata_q;
  assign cpu_stall = c_req & ~((c_gnt_q & c_we) | c_rvalid_q | c_err_q);

endmodule
